// File: rtl/rpd_buffer_pkg.sv
// rtl/rpd_buffer_pkg.sv - shared status type and sizing helpers for the sample ring buffer
package rpd_buffer_pkg;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } status_t;

  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int value);
    return (value >= 2) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/ring_buffer_mem.sv
// rtl/ring_buffer_mem.sv - simple dual-port sample storage with registered read, no reset
module ring_buffer_mem #(
  parameter int DATA_WIDTH = 12,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Read-first: a read and write to the same slot returns the old sample.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/sample_ring_buffer.sv
// rtl/sample_ring_buffer.sv - count-based sample ring buffer with optional overwrite of oldest data
module sample_ring_buffer
  import rpd_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int DEPTH      = 16,
  parameter int OVERWRITE  = 0,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  input  logic                          rd_en,
  input  logic                          flush,
  input  logic                          clr_err,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          wr_ack,
  output logic                          rd_ack,
  output logic                          full,
  output logic                          empty,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic [level_width(DEPTH)-1:0] level,
  output logic                          overflow,
  output logic                          underflow,
  output logic                          dropped
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = level_width(DEPTH);

  if (!is_pow2(DEPTH)) begin : g_bad_depth
    $error("sample_ring_buffer: DEPTH must be a power of two >= 2");
  end
  if (AF_LEVEL < 0 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("sample_ring_buffer: AF_LEVEL outside 0..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH) begin : g_bad_ae
    $error("sample_ring_buffer: AE_LEVEL outside 0..DEPTH");
  end

  logic [AW-1:0]         wr_ptr, wr_ptr_next;
  logic [AW-1:0]         rd_ptr, rd_ptr_next;
  logic [LW-1:0]         level_q, level_next;
  status_t               status_q, status_next;
  logic                  rd_ok, wr_ok, drop, ov_set, un_set;
  logic                  have_data;
  logic [DATA_WIDTH-1:0] mem_q;

  // Empty-time writes never satisfy a same-cycle read: acceptance uses registered status.
  always_comb begin
    rd_ok  = rd_en && !status_q.empty && !flush;
    wr_ok  = wr_en && !flush && (!status_q.full || (OVERWRITE != 0) || rd_ok);
    drop   = wr_ok && status_q.full && !rd_ok;
    ov_set = wr_en && !flush && !wr_ok;
    un_set = rd_en && !flush && status_q.empty;
  end

  always_comb begin
    wr_ptr_next = wr_ptr;
    rd_ptr_next = rd_ptr;
    level_next  = level_q;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      level_next  = '0;
    end else begin
      if (wr_ok) begin
        wr_ptr_next = wr_ptr + AW'(1);
      end
      if (rd_ok || drop) begin
        rd_ptr_next = rd_ptr + AW'(1);
      end
      if (wr_ok && !rd_ok && !drop) begin
        level_next = level_q + LW'(1);
      end else if (rd_ok && !wr_ok) begin
        level_next = level_q - LW'(1);
      end
    end

    status_next.full         = (level_next == LW'(DEPTH));
    status_next.empty        = (level_next == '0);
    status_next.almost_full  = (int'(level_next) >= AF_LEVEL);
    status_next.almost_empty = (int'(level_next) <= AE_LEVEL);
    // A flush leaves the sticky flags exactly as they were.
    status_next.overflow     = flush ? status_q.overflow
                                     : (ov_set || (status_q.overflow && !clr_err));
    status_next.underflow    = flush ? status_q.underflow
                                     : (un_set || (status_q.underflow && !clr_err));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level_q   <= '0;
      status_q  <= '{full: 1'b0, empty: 1'b1, almost_full: 1'b0, almost_empty: 1'b1,
                     overflow: 1'b0, underflow: 1'b0};
      wr_ack    <= 1'b0;
      rd_ack    <= 1'b0;
      dropped   <= 1'b0;
      have_data <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr_next;
      rd_ptr    <= rd_ptr_next;
      level_q   <= level_next;
      status_q  <= status_next;
      wr_ack    <= wr_ok;
      rd_ack    <= rd_ok;
      dropped   <= drop;
      if (rd_ok) begin
        have_data <= 1'b1;
      end
    end
  end

  ring_buffer_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .ADDR_WIDTH(AW)
  ) u_mem (
    .clk    (clk),
    .wr_en  (wr_ok && !rst),
    .wr_addr(wr_ptr),
    .wr_data(wr_data),
    .rd_en  (rd_ok && !rst),
    .rd_addr(rd_ptr),
    .rd_data(mem_q)
  );

  // The storage read register has no reset, so mask it until the first accepted read.
  assign rd_data      = have_data ? mem_q : '0;
  assign level        = level_q;
  assign full         = status_q.full;
  assign empty        = status_q.empty;
  assign almost_full  = status_q.almost_full;
  assign almost_empty = status_q.almost_empty;
  assign overflow     = status_q.overflow;
  assign underflow    = status_q.underflow;

endmodule

// File: tb/tb_sample_ring_buffer.sv
// tb/tb_sample_ring_buffer.sv - self-checking bench for sample_ring_buffer (plain and overwrite instances)
module tb_sample_ring_buffer;

  localparam int DW    = 12;
  localparam int DEPTH = 4;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 1;

  typedef logic [DW-1:0] sample_t;

  logic    clk = 1'b0;
  logic    rst = 1'b1;
  logic    wr_en = 1'b0;
  sample_t wr_data = '0;
  logic    rd_en = 1'b0;
  logic    flush = 1'b0;
  logic    clr_err = 1'b0;

  sample_t    rd_data_o [2];
  logic       wr_ack_o [2];
  logic       rd_ack_o [2];
  logic       full_o [2];
  logic       empty_o [2];
  logic       af_o [2];
  logic       ae_o [2];
  logic [2:0] level_o [2];
  logic       ov_o [2];
  logic       un_o [2];
  logic       drop_o [2];

  int checks = 0;
  int errors = 0;
  bit started = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    sample_ring_buffer #(
      .DATA_WIDTH(DW),
      .DEPTH     (DEPTH),
      .OVERWRITE (g)
    ) dut (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (wr_en),
      .wr_data     (wr_data),
      .rd_en       (rd_en),
      .flush       (flush),
      .clr_err     (clr_err),
      .rd_data     (rd_data_o[g]),
      .wr_ack      (wr_ack_o[g]),
      .rd_ack      (rd_ack_o[g]),
      .full        (full_o[g]),
      .empty       (empty_o[g]),
      .almost_full (af_o[g]),
      .almost_empty(ae_o[g]),
      .level       (level_o[g]),
      .overflow    (ov_o[g]),
      .underflow   (un_o[g]),
      .dropped     (drop_o[g])
    );
  end

  // Reference model: the buffer is just a queue of samples, oldest first.
  sample_t mq [2][$];
  sample_t m_rdd [2];
  bit      m_ov [2];
  bit      m_un [2];
  bit      m_wack [2];
  bit      m_rack [2];
  bit      m_drop [2];

  task automatic model_step(input int i);
    bit was_empty, was_full, r, w, d;
    if (rst) begin
      mq[i].delete();
      m_rdd[i] = '0; m_ov[i] = 0; m_un[i] = 0;
      m_wack[i] = 0; m_rack[i] = 0; m_drop[i] = 0;
    end else if (flush) begin
      mq[i].delete();
      m_wack[i] = 0; m_rack[i] = 0; m_drop[i] = 0;
    end else begin
      was_empty = (mq[i].size() == 0);
      was_full  = (mq[i].size() == DEPTH);
      r = rd_en && !was_empty;
      w = wr_en && (!was_full || i == 1 || r);
      d = w && was_full && !r;
      if (r) m_rdd[i] = mq[i].pop_front();
      if (d) void'(mq[i].pop_front());
      if (w) mq[i].push_back(wr_data);
      m_ov[i] = (wr_en && !w) ? 1'b1 : (clr_err ? 1'b0 : m_ov[i]);
      m_un[i] = (rd_en && was_empty) ? 1'b1 : (clr_err ? 1'b0 : m_un[i]);
      m_rack[i] = r; m_wack[i] = w; m_drop[i] = d;
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) model_step(i);
    started = 1;
  end

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] at %0t: got %0h, expected %0h", name, idx, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        int n;
        n = mq[i].size();
        check("level", i, 32'(level_o[i]), 32'(n));
        check("full", i, 32'(full_o[i]), 32'(n == DEPTH));
        check("empty", i, 32'(empty_o[i]), 32'(n == 0));
        check("almost_full", i, 32'(af_o[i]), 32'(n >= AF));
        check("almost_empty", i, 32'(ae_o[i]), 32'(n <= AE));
        check("rd_data", i, 32'(rd_data_o[i]), 32'(m_rdd[i]));
        check("wr_ack", i, 32'(wr_ack_o[i]), 32'(m_wack[i]));
        check("rd_ack", i, 32'(rd_ack_o[i]), 32'(m_rack[i]));
        check("overflow", i, 32'(ov_o[i]), 32'(m_ov[i]));
        check("underflow", i, 32'(un_o[i]), 32'(m_un[i]));
        check("dropped", i, 32'(drop_o[i]), 32'(m_drop[i]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; wr_en = 0; rd_en = 0; flush = 0; clr_err = 0;
  endtask

  initial begin
    tick(); tick();
    check("lit_reset_level", 0, 32'(level_o[0]), 0);
    check("lit_reset_empty", 0, 32'(empty_o[0]), 1);
    check("lit_reset_ae", 0, 32'(ae_o[0]), 1);
    check("lit_reset_rd_data", 0, 32'(rd_data_o[0]), 0);

    idle();
    for (int k = 1; k <= 4; k++) begin
      wr_en = 1; wr_data = sample_t'(k);
      tick();
      check("lit_fill_wr_ack", k, 32'(wr_ack_o[0]), 1);
    end
    check("lit_fill_level", 0, 32'(level_o[0]), 4);
    check("lit_fill_full", 0, 32'(full_o[0]), 1);
    wr_data = 12'h005;
    tick();
    check("lit_ovf_wr_ack", 0, 32'(wr_ack_o[0]), 0);
    check("lit_ovf_flag", 0, 32'(ov_o[0]), 1);
    check("lit_ovf_level", 0, 32'(level_o[0]), 4);
    check("lit_ow_drop5", 1, 32'(drop_o[1]), 1);
    check("lit_ow_no_ovf", 1, 32'(ov_o[1]), 0);
    wr_data = 12'h006;
    tick();
    check("lit_ow_drop6", 1, 32'(drop_o[1]), 1);
    check("lit_ow_level", 1, 32'(level_o[1]), 4);

    idle(); rd_en = 1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("lit_drain_rd_data", k, 32'(rd_data_o[0]), 32'(k));
      check("lit_drain_rd_ack", k, 32'(rd_ack_o[0]), 1);
      check("lit_ow_drain_rd_data", k, 32'(rd_data_o[1]), 32'(k + 2));
    end
    tick();
    check("lit_unf_rd_ack", 0, 32'(rd_ack_o[0]), 0);
    check("lit_unf_rd_data", 0, 32'(rd_data_o[0]), 4);
    check("lit_unf_flag", 0, 32'(un_o[0]), 1);
    check("lit_unf_empty", 0, 32'(empty_o[0]), 1);

    idle(); clr_err = 1;
    tick();
    check("lit_clr_ovf", 0, 32'(ov_o[0]), 0);
    check("lit_clr_unf", 0, 32'(un_o[0]), 0);

    idle(); wr_en = 1;
    wr_data = 12'h010; tick();
    wr_data = 12'h011; tick();
    rd_en = 1;
    for (int k = 0; k < 6; k++) begin
      wr_data = sample_t'(12'h012 + k);
      tick();
      check("lit_stream_rd_data", k, 32'(rd_data_o[0]), 32'(12'h010 + k));
      check("lit_stream_level", k, 32'(level_o[0]), 2);
    end
    rd_en = 0; wr_data = 12'h020;
    tick();
    check("lit_pre_flush_level", 0, 32'(level_o[0]), 3);
    flush = 1; rd_en = 1; wr_en = 1;
    tick();
    check("lit_flush_rd_ack", 0, 32'(rd_ack_o[0]), 0);
    check("lit_flush_wr_ack", 0, 32'(wr_ack_o[0]), 0);
    check("lit_flush_level", 0, 32'(level_o[0]), 0);
    check("lit_flush_empty", 0, 32'(empty_o[0]), 1);
    check("lit_flush_rd_data", 0, 32'(rd_data_o[0]), 32'h015);

    idle(); rd_en = 1;
    tick();
    check("lit_unf_again", 0, 32'(un_o[0]), 1);
    idle(); wr_en = 1;
    for (int k = 0; k < 3; k++) begin
      wr_data = sample_t'(12'h030 + k);
      tick();
    end
    check("lit_pre_rst_level", 0, 32'(level_o[0]), 3);
    rst = 1;
    tick();
    check("lit_rst_level", 0, 32'(level_o[0]), 0);
    check("lit_rst_empty", 0, 32'(empty_o[0]), 1);
    check("lit_rst_ae", 0, 32'(ae_o[0]), 1);
    check("lit_rst_af", 0, 32'(af_o[0]), 0);
    check("lit_rst_full", 0, 32'(full_o[0]), 0);
    check("lit_rst_rd_data", 0, 32'(rd_data_o[0]), 0);
    check("lit_rst_wr_ack", 0, 32'(wr_ack_o[0]), 0);
    check("lit_rst_unf", 0, 32'(un_o[0]), 0);

    for (int c = 0; c < 3000; c++) begin
      int wp;
      wp = ((c / 64) % 2 == 0) ? 75 : 25;
      rst     = ($urandom_range(0, 199) == 0);
      flush   = ($urandom_range(0, 59) == 0);
      clr_err = ($urandom_range(0, 24) == 0);
      wr_en   = ($urandom_range(0, 99) < wp);
      rd_en   = ($urandom_range(0, 99) < (100 - wp));
      wr_data = sample_t'($urandom);
      tick();
    end

    idle();
    tick(); tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sample_ring_buffer.md
SAMPLE_RING_BUFFER -- requirements
Module: sample_ring_buffer

Interface
REQ-001 Parameter DATA_WIDTH, default 12, width of one stored sample.
REQ-002 Parameter DEPTH, default 16, capacity in samples; SHALL be a power of two, >= 2.
REQ-003 Parameter OVERWRITE, default 0; 1 = write when full replaces the oldest sample.
REQ-004 Parameters AF_LEVEL, default DEPTH-2, and AE_LEVEL, default 1: almost-full/almost-empty thresholds.
REQ-005 clk  in  1  sole clock, all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 wr_en  in  1  write request, one sample per cycle.
REQ-008 wr_data  in  DATA_WIDTH  sample to write.
REQ-009 rd_en  in  1  read request, one sample per cycle.
REQ-010 flush  in  1  discard all contents.
REQ-011 clr_err  in  1  clear sticky error flags.
REQ-012 rd_data  out  DATA_WIDTH  sample read out, registered.
REQ-013 wr_ack / rd_ack  out  1 each  one-cycle pulse: request of previous cycle accepted.
REQ-014 full, empty, almost_full, almost_empty  out  1 each  registered status.
REQ-015 level  out  $clog2(DEPTH)+1  samples currently stored, 0..DEPTH.
REQ-016 overflow, underflow  out  1 each  sticky error flags.
REQ-017 dropped  out  1  one-cycle pulse: oldest sample overwritten (OVERWRITE=1 only).

Function
REQ-018 Full capacity SHALL be DEPTH samples (count-based, no reserved slot); pointers $clog2(DEPTH) bits, wrap naturally modulo DEPTH.
REQ-019 Write accepted when !full, or when full and OVERWRITE=1, or when full and a read is accepted the same cycle; sample stored at wr_ptr, wr_ptr+1, wr_ack=1 next cycle.
REQ-020 Write rejected otherwise: memory/pointers unchanged, wr_ack=0, overflow set.
REQ-021 Read accepted when !empty: rd_data <= mem[rd_ptr], rd_ptr+1, rd_ack=1, all on the next edge (1-cycle latency).
REQ-022 Read when empty: rejected, rd_ack=0, rd_data holds previous value, underflow set; a same-cycle write to an empty buffer is accepted and SHALL NOT satisfy that read.
REQ-023 rd_data SHALL hold its value in every cycle without an accepted read.
REQ-024 Simultaneous accepted read and write: level unchanged; read returns the oldest sample, never the one being written.
REQ-025 OVERWRITE=1, full, write without read: sample stored, rd_ptr+1, level stays DEPTH, dropped=1, overflow not set.
REQ-026 level updates +1 (write only), -1 (read only), 0 otherwise; full=(level==DEPTH), empty=(level==0), almost_full=(level>=AF_LEVEL), almost_empty=(level<=AE_LEVEL), all reflecting post-update level.
REQ-027 flush SHALL take priority over rd_en/wr_en: next cycle pointers=0, level=0, empty=1, acks=0, dropped=0; rd_data and error flags unchanged.
REQ-028 clr_err clears overflow/underflow next cycle; a new error in the same cycle wins (flag stays 1).

Reset
REQ-029 rst SHALL override all inputs; next cycle: pointers=0, level=0, empty=1, almost_empty=1, full=0, almost_full=0, rd_data=0, wr_ack=rd_ack=0, overflow=underflow=0, dropped=0.
REQ-030 Memory contents SHALL NOT be reset; rst mid-operation discards stored samples and any request of that cycle.

Structure
REQ-031 Shared package rpd_buffer_pkg SHALL hold the status struct (full, empty, almost_full, almost_empty, overflow, underflow) and a function computing level width from DEPTH.
REQ-032 Storage SHALL be a sub-module ring_buffer_mem: simple dual-port, one write port, one registered read port, no reset.
REQ-033 Elaboration SHALL fail for non-power-of-two DEPTH or AF_LEVEL/AE_LEVEL outside 0..DEPTH.

Verification (DEPTH=4, DATA_WIDTH=12 unless stated)
REQ-034 Reset, write 0x001..0x004 -> level 4, full=1, wr_ack each cycle; fifth write 0x005 -> wr_ack=0, overflow=1, level 4.
REQ-035 Read four from full -> rd_data 0x001..0x004 one cycle after each rd_en, rd_ack=1; fifth read -> rd_ack=0, rd_data stays 0x004, underflow=1, empty=1.
REQ-036 Level 2, simultaneous rd_en+wr_en for 6 cycles -> level stays 2, data returned in write order across pointer wrap.
REQ-037 OVERWRITE=1, write 0x001..0x006 -> dropped pulses on writes 5 and 6, then reads return 0x003..0x006.
REQ-038 Level 3, assert flush with rd_en+wr_en -> no acks, next cycle level 0, empty=1, rd_data unchanged.
REQ-039 Assert rst at level 3 with wr_en -> next cycle level 0, all outputs at reset values; clr_err clears flags set earlier.
